fp_result_normalizer: RTL and testbench

//  Back end of the single-precision floating-point adder. Consumes the raw
//  25-bit mantissa sum from the 24-bit mantissa adder/subtractor, together

---
 rtl/fp_result_normalizer.sv | 91 +++++++++
 tb/tb_fp_result_normalizer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_normalizer.sv
// Back end of the binary32 adder: normalizes the raw 25-bit mantissa sum one
// bit per cycle, then packs sign/exponent/fraction with truncation rounding.
module fp_result_normalizer #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic [EXP_W-1:0]        in_exp,
   input  logic [MANT_W:0]         in_sum,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+MANT_W-1:0] out_result,
   output logic                    out_overflow,
   output logic                    out_zero,
   output logic                    busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] NORM = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [EXP_W:0] E_ONE = {{EXP_W{1'b0}}, 1'b1};
   localparam logic [EXP_W:0] E_MAX = {1'b0, {EXP_W{1'b1}}};

   logic [1:0]      state;
   logic            s;
   logic [MANT_W:0] m;
   logic [EXP_W:0]  e;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         s            <= 1'b0;
         m            <= '0;
         e            <= '0;
         out_result   <= '0;
         out_overflow <= 1'b0;
         out_zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  s            <= in_sign;
                  m            <= in_sum;
                  // subnormal inputs carry exponent 0 but scale like exponent 1
                  e            <= (in_exp == '0) ? E_ONE : {1'b0, in_exp};
                  out_overflow <= 1'b0;
                  out_zero     <= 1'b0;
                  state        <= NORM;
               end
            end
            NORM: begin
               if (m == '0) begin
                  out_result <= '0;
                  out_zero   <= 1'b1;
                  state      <= DONE;
               end else if (m[MANT_W]) begin
                  m <= m >> 1;
                  e <= e + E_ONE;
               end else if (e >= E_MAX) begin
                  out_result   <= {s, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
                  out_overflow <= 1'b1;
                  state        <= DONE;
               end else if (m[MANT_W-1]) begin
                  out_result <= {s, e[EXP_W-1:0], m[MANT_W-2:0]};
                  state      <= DONE;
               end else if (e == E_ONE) begin
                  out_result <= {s, {EXP_W{1'b0}}, m[MANT_W-2:0]};
                  state      <= DONE;
               end else begin
                  m <= m << 1;
                  e <= e - E_ONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp_result_normalizer.sv
// Randomized bench for fp_result_normalizer: a leading-one based reference model
// predicts result, flags and latency; one negedge monitor compares every cycle.
module tb_fp_result_normalizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [24:0] in_sum;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_zero;
   logic        busy;

   fp_result_normalizer #(.MANT_W(24), .EXP_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sign      (in_sign),
      .in_exp       (in_exp),
      .in_sum       (in_sum),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_overflow (out_overflow),
      .out_zero     (out_zero),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      bit          ovf;
      bit          zero;
      int          lat;
   } model_t;

   int     n_chk  = 0;
   int     n_fail = 0;
   int     cyc    = 0;
   int     acc_cyc;
   bit     first;
   bit [1:0] rdy_mode = 2'd2;
   model_t exp_q[$];
   model_t mdl;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Normalization expressed through the leading-one position instead of stepping.
   function automatic model_t model(bit s, bit [7:0] ex, bit [24:0] sum);
      model_t      r;
      int unsigned m;
      int          e;
      int          need;
      int unsigned fexp;
      m     = 32'(sum);
      e     = (ex == 8'd0) ? 1 : int'(ex);
      r.lat = 2;
      r.ovf = 1'b0;
      r.zero = 1'b0;
      if (m == 0) begin
         r.res  = 32'h0;
         r.zero = 1'b1;
         return r;
      end
      if (m >= 32'h0100_0000) begin
         m = m / 2;
         e = e + 1;
         r.lat = r.lat + 1;
      end
      if (e >= 255) begin
         r.res = {s, 8'hFF, 23'h0};
         r.ovf = 1'b1;
         return r;
      end
      need = 23 - ($clog2(m + 1) - 1);
      if (need > e - 1) need = e - 1;
      m     = m << need;
      e     = e - need;
      r.lat = r.lat + need;
      fexp  = (m >= 32'h0080_0000) ? 32'(e) : 32'd0;
      r.res = {s, 8'(fexp), 23'(m)};
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         first = 1'b0;
      end else begin
         chk("ready_vs_busy", 32'(in_ready), 32'(!busy));
         if (in_valid && in_ready) begin
            mdl = model(in_sign, in_exp, in_sum);
            exp_q.push_back(mdl);
            acc_cyc = cyc + 1;
            first   = 1'b1;
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL spurious_out_valid: got 1 expected 0 (t=%0t)", $time);
            end else begin
               if (first) begin
                  chk("latency", 32'(cyc - acc_cyc + 1), 32'(exp_q[0].lat));
                  first = 1'b0;
               end
               chk("result",   out_result,          exp_q[0].res);
               chk("overflow", 32'(out_overflow),   32'(exp_q[0].ovf));
               chk("zero",     32'(out_zero),       32'(exp_q[0].zero));
               chk("in_ready_in_done", 32'(in_ready), 32'd0);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         2'd0:    out_ready = 1'($urandom_range(0, 1));
         2'd1:    out_ready = 1'b0;
         default: out_ready = 1'b1;
      endcase
   end

   task automatic send(input bit s, input bit [7:0] ex, input bit [24:0] sum);
      int t = 0;
      while (!in_ready && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL in_ready_timeout: got 0 expected 1 (t=%0t)", $time);
      end
      in_sign  = s;
      in_exp   = ex;
      in_sum   = sum;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((busy || exp_q.size() != 0) && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_idle", 32'(busy), 32'd0);
   endtask

   model_t pin;
   int     k;
   bit [24:0] rsum;
   bit [7:0]  rexp;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = 8'd0;
      in_sum    = 25'd0;
      out_ready = 1'b1;

      pin = model(1'b0, 8'd127, 25'h0800000);
      chk("pin1_res", pin.res, 32'h3F80_0000);
      chk("pin1_lat", 32'(pin.lat), 32'd2);
      pin = model(1'b0, 8'd127, 25'h1000000);
      chk("pin2_res", pin.res, 32'h4000_0000);
      chk("pin2_lat", 32'(pin.lat), 32'd3);
      pin = model(1'b0, 8'd130, 25'h0000001);
      chk("pin3_res", pin.res, 32'h3580_0000);
      chk("pin3_lat", 32'(pin.lat), 32'd25);
      pin = model(1'b0, 8'd3, 25'h0000100);
      chk("pin4_res", pin.res, 32'h0000_0400);
      chk("pin4_zero", 32'(pin.zero), 32'd0);
      pin = model(1'b1, 8'd254, 25'h1000000);
      chk("pin5_res", pin.res, 32'hFF80_0000);
      chk("pin5_ovf", 32'(pin.ovf), 32'd1);
      pin = model(1'b1, 8'd17, 25'h0);
      chk("pin6_res", pin.res, 32'h0);
      chk("pin6_zero", 32'(pin.zero), 32'd1);

      #22;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result",    out_result,     32'h0);
      chk("rst_overflow",  32'(out_overflow), 32'd0);
      chk("rst_zero",      32'(out_zero),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      rdy_mode = 2'd2;
      send(1'b0, 8'd127, 25'h0800000); drain();
      send(1'b0, 8'd127, 25'h1000000); drain();
      send(1'b0, 8'd130, 25'h0000001); drain();
      send(1'b0, 8'd3,   25'h0000100); drain();
      send(1'b1, 8'd254, 25'h1000000); drain();
      send(1'b1, 8'd90,  25'h0);       drain();
      send(1'b0, 8'd255, 25'h0800000); drain();
      send(1'b1, 8'd0,   25'h0400000); drain();

      // hold the result in DONE with out_ready low
      rdy_mode = 2'd1;
      @(posedge clk);
      #1;
      send(1'b1, 8'd100, 25'h0C00000);
      repeat (6) @(posedge clk);
      #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", out_result, 32'hB240_0000);
      rdy_mode = 2'd2;
      drain();

      // reset while still shifting
      send(1'b0, 8'd130, 25'h0000001);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy",      32'(busy),      32'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      repeat (30) @(posedge clk);
      #1;
      chk("midrst_no_output", 32'(out_valid), 32'd0);

      rdy_mode = 2'd0;
      for (int i = 0; i < 300; i++) begin
         k    = $urandom_range(0, 25);
         rsum = 25'($urandom) & 25'((33'd1 << k) - 1);
         if (k > 0) rsum = rsum | 25'(33'd1 << (k - 1));
         case ($urandom_range(0, 3))
            0:       rexp = 8'($urandom_range(0, 4));
            1:       rexp = 8'($urandom_range(250, 255));
            default: rexp = 8'($urandom_range(0, 255));
         endcase
         send(1'($urandom_range(0, 1)), rexp, rsum);
      end
      rdy_mode = 2'd2;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
